i2f_share_arbiter: RTL and testbench
====================================

Name: i2f_share_arbiter

Overview:
- Shares one integer-to-float converter among NUM_REQ requesters in the image-thresholding pipeline, e.g. histogram bin counts, cumulative weights and cumulative sums feeding the threshold-score stage.
- Grants requesters in round-robin order and keeps exactly one conversion outstanding, because the converter silently drops inputs while busy.
- Times out on a converter that never answers.
- Routes each float result back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, integer operand width and float result width.
- TIMEOUT, 15, maximum cycles spent in WAIT before the request is abandoned (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid; held high until accepted.
- req_data  in  NUM_REQ*DATA_W  per-requester integer operand; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_data  out  DATA_W  float result, valid with rsp_valid.
- err_timeout  out  1  one-cycle pulse when a conversion is abandoned.
- busy  out  1  high in any state other than IDLE.
- conv_valid_in  out  1  converter input strobe.
- conv_int_value  out  DATA_W  converter operand.
- conv_float_out  in  DATA_W  converter result.
- conv_valid_out  in  1  converter result strobe.

Behaviour:
- Reset, asynchronous, active-high on clk:
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_data=0, err_timeout=0, conv_valid_in=0, conv_int_value=0.
  - Timeout counter=0, captured operand and result=0.
- Reset mid-operation discards the in-flight request with no response. A late conv_valid_out after reset is ignored.
- States and transitions:
  - IDLE:
    - Selects grant = first i with req_valid[i]=1, searching from last_grant+1 upward with wrap-around.
    - req_ready[grant] is driven combinationally high only in IDLE, only when some req_valid is set. Otherwise req_ready=0.
    - On that edge: latch req_data[grant] and grant, then go to ISSUE.
  - ISSUE:
    - conv_valid_in=1 for exactly one cycle, conv_int_value=latched operand.
    - Go to WAIT and clear the counter.
  - WAIT:
    - On conv_valid_out=1: capture conv_float_out, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT: pulse err_timeout next cycle, set last_grant=grant, return to IDLE, issue no response.
  - RESP:
    - Registered rsp_valid[grant]=1 and rsp_data=captured value for one cycle.
    - Set last_grant=grant and return to IDLE.
- Latency:
  - With a converter answering k cycles after conv_valid_in, rsp_valid rises k+2 cycles after the accept edge. The current converter has k=2, so rsp_valid rises 4 cycles after accept.
  - Back-to-back minimum spacing between accepts is k+3 cycles.
- conv_valid_out arriving outside WAIT is ignored.
- conv_valid_out arriving on the same cycle the counter would hit TIMEOUT counts as success; no error is raised.
- rsp_data holds its last value between strobes.
- No requester is granted twice in a row while another requester is pending.
- A requester deasserting req_valid before acceptance simply drops out of arbitration. This is not an error.
- conv_int_value holds the latched operand outside ISSUE; only conv_valid_in qualifies it.

Decomposition:
- Package i2f_arb_pkg:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - DATA_W default.
  - Counter width, derived as 8 bits.
  - Float zero constant 32'h0000_0000.
- Sub-module rr_arbiter (NUM_REQ): purely combinational; takes req vector and last_grant, returns one-hot grant, index and any_req.
- All sequencing stays in the top module.

Test Plan:
- Single request, converter model with k=2: requester 0 sends 5 -> req_ready[0] for 1 cycle, conv_valid_in 1 cycle later with 5, rsp_valid[0] 4 cycles after accept, rsp_data=32'h40A0_0000.
- Zero operand: requester 2 sends 0 -> rsp_valid[2], rsp_data=32'h0000_0000.
- All four requesters held valid with values 1, 2, 3, 255:
  - Accept order is 0,1,2,3, then 0 again.
  - Responses are 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h437F_0000 on matching rsp_valid bits.
  - Accepts are spaced 5 cycles apart.
- Timeout: converter stub never answers -> err_timeout pulse after 15 WAIT cycles, no rsp_valid, busy drops, next pending requester (1) is granted.
- Reset asserted in WAIT, with converter responding 1 cycle after reset release -> all outputs return to reset values immediately, stray result ignored, no rsp_valid, requester 0 granted first afterwards.
- Spurious conv_valid_out in IDLE with requester 1 pending -> ignored; requester 1 still receives its own correct result.

Source files
------------

// File: rtl/i2f_share_arbiter_pkg.sv
// Shared types and constants for the integer-to-float converter arbiter.
// Kept separate so the arbiter and its sub-blocks agree on state encoding and widths.
package i2f_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 8;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/i2f_share_arbiter_rr_arbiter.sv
// Combinational round-robin selector: finds the first requester above last_grant,
// wrapping around, so the most recently served requester always has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  always_comb begin
    // NOTE: every output is given a default before the search loop; a path that
    // skips an assignment would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int cand;
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2f_share_arbiter.sv
// Shares a single integer-to-float converter among NUM_REQ requesters with one
// conversion outstanding at a time, a WAIT timeout, and per-requester result routing.
module i2f_share_arbiter
  import i2f_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      err_timeout,
  output logic                      busy,
  output logic                      conv_valid_in,
  output logic [DATA_W-1:0]         conv_int_value,
  input  logic [DATA_W-1:0]         conv_float_out,
  input  logic                      conv_valid_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q;
  logic [IDX_W-1:0]     grant_q;
  logic [DATA_W-1:0]    operand_q;
  logic [DATA_W-1:0]    result_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 any_req;
  logic                 timed_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (gnt_onehot),
    .grant_idx  (gnt_idx),
    .any_req    (any_req)
  );

  // A result arriving on the final WAIT cycle wins over the timeout.
  assign timed_out = (state_q == WAIT) && !conv_valid_out && (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    conv_valid_in = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt_onehot;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        conv_valid_in = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        if (conv_valid_out) state_d = RESP;
        else if (timed_out) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      operand_q    <= '0;
      result_q     <= DATA_W'(FLOAT_ZERO);
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= DATA_W'(FLOAT_ZERO);
      err_q        <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            operand_q <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            grant_q   <= gnt_idx;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (conv_valid_out) begin
            result_q <= conv_float_out;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timed_out) begin
              err_q        <= 1'b1;
              last_grant_q <= grant_q;
            end
          end
        end
        RESP: begin
          rsp_valid_q  <= NUM_REQ'(1) << grant_q;
          rsp_data_q   <= result_q;
          last_grant_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign err_timeout    = err_q;
  assign busy           = (state_q != IDLE);
  assign conv_int_value = operand_q;

endmodule

// File: tb/tb_i2f_share_arbiter.sv
// Self-checking bench for i2f_share_arbiter: a k=2 converter model, directed stimulus
// that queues expected responses, and an independent monitor that checks them.
module tb_i2f_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      err_timeout;
  logic                      busy;
  logic                      conv_valid_in;
  logic [DATA_W-1:0]         conv_int_value;
  logic [DATA_W-1:0]         conv_float_out;
  logic                      conv_valid_out;

  i2f_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .err_timeout    (err_timeout),
    .busy           (busy),
    .conv_valid_in  (conv_valid_in),
    .conv_int_value (conv_int_value),
    .conv_float_out (conv_float_out),
    .conv_valid_out (conv_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unsigned integer to IEEE-754 single, truncating beyond 24 significant bits.
  function automatic logic [31:0] i2f(input logic [31:0] v);
    int          p;
    logic [31:0] m;
    if (v == 32'd0) return 32'h0;
    p = 31;
    while (!v[p]) p--;
    m = (p <= 23) ? (v << (23 - p)) : (v >> (p - 23));
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Converter model: answers two cycles after conv_valid_in; conv_en=0 models a dead converter.
  logic        conv_en = 1'b1;
  logic        v1, v2;
  logic [31:0] d1, d2;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_data  = 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= conv_valid_in && conv_en;
      d1 <= i2f(conv_int_value);
      v2 <= v1;
      d2 <= d1;
    end
  end

  assign conv_valid_out = v2 | inj_valid;
  assign conv_float_out = inj_valid ? inj_data : d2;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   last_rsp_cyc = 0;
  logic err_allowed  = 1'b0;

  task automatic push_exp(input int idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid != '0) begin
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.idx));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
    if (!reset && err_timeout) check("err_timeout_allowed", 64'(err_allowed), 64'h1);
  end

  task automatic set_req(input int i, input logic v, input logic [31:0] d);
    req_valid[i]                = v;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Called at/just after a negedge; returns at the negedge of the accepting cycle.
  task automatic wait_accept(output int idx, output int acc);
    idx = -1;
    acc = 0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready != '0) begin
        check("req_ready_onehot", 64'($onehot(req_ready)), 64'h1);
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (idx < 0) check("accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'h0);
    check({tag, "_err"}, 64'(err_timeout), 64'h0);
    check({tag, "_conv_valid_in"}, 64'(conv_valid_in), 64'h0);
    check({tag, "_conv_int_value"}, 64'(conv_int_value), 64'h0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, acc, prev, err_cyc;
    logic [31:0] vals [4];

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single request from requester 0, operand 5.
    set_req(0, 1'b1, 32'd5);
    push_exp(0, 32'h40A0_0000);
    wait_accept(idx, acc);
    check("t1_grant", 64'(idx), 64'd0);
    @(negedge clk);
    check("t1_conv_valid_in", 64'(conv_valid_in), 64'h1);
    check("t1_conv_int_value", 64'(conv_int_value), 64'd5);
    check("t1_ready_in_issue", 64'(req_ready), 64'h0);
    check("t1_busy", 64'(busy), 64'h1);
    set_req(0, 1'b0, 32'd0);
    @(negedge clk);
    check("t1_conv_valid_in_once", 64'(conv_valid_in), 64'h0);
    drain();
    check("t1_latency", 64'(last_rsp_cyc - acc), 64'd4);
    check("t1_rsp_data_hold", 64'(rsp_data), 64'h40A0_0000);

    // Zero operand from requester 2.
    set_req(2, 1'b1, 32'd0);
    push_exp(2, 32'h0000_0000);
    wait_accept(idx, acc);
    check("t2_grant", 64'(idx), 64'd2);
    @(negedge clk);
    set_req(2, 1'b0, 32'd0);
    drain();

    // All four held valid: round-robin order and back-to-back spacing.
    do_reset();
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd255;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, vals[i]);
    push_exp(0, 32'h3F80_0000);
    push_exp(1, 32'h4000_0000);
    push_exp(2, 32'h4040_0000);
    push_exp(3, 32'h437F_0000);
    push_exp(0, 32'h3F80_0000);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(idx, acc);
      check("t3_grant_order", 64'(idx), 64'(k % 4));
      if (k > 0) check("t3_spacing", 64'(acc - prev), 64'd5);
      prev = acc;
      @(negedge clk);
    end
    req_valid = '0;
    drain();

    // Converter never answers: timeout, then requester 1 is granted.
    do_reset();
    conv_en     = 1'b0;
    err_allowed = 1'b1;
    set_req(0, 1'b1, 32'd10);
    set_req(1, 1'b1, 32'd7);
    push_exp(1, 32'h40E0_0000);
    wait_accept(idx, acc);
    check("t4_grant_first", 64'(idx), 64'd0);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0);
    err_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      if (err_timeout) begin
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t4_err_seen", 64'(err_cyc >= 0), 64'h1);
    check("t4_err_timing", 64'(err_cyc - acc), 64'd16);
    check("t4_busy_low", 64'(busy), 64'h0);
    check("t4_next_grant", 64'(req_ready), 64'b0010);
    conv_en = 1'b1;
    @(negedge clk);
    set_req(1, 1'b0, 32'd0);
    check("t4_err_one_cycle", 64'(err_timeout), 64'h0);
    err_allowed = 1'b0;
    drain();

    // Reset while in WAIT, then a stray result after release.
    conv_en = 1'b0;
    set_req(0, 1'b1, 32'd9);
    wait_accept(idx, acc);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0);
    @(negedge clk);
    check("t5_in_wait_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_mid");
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    conv_en = 1'b1;
    @(negedge clk);
    inj_data  = 32'hDEAD_BEEF;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    @(negedge clk);
    check("t5_stray_busy", 64'(busy), 64'h0);
    check("t5_stray_rsp_data", 64'(rsp_data), 64'h0);
    set_req(0, 1'b1, 32'd3);
    set_req(3, 1'b1, 32'd4);
    push_exp(0, 32'h4040_0000);
    push_exp(3, 32'h4080_0000);
    wait_accept(idx, acc);
    check("t5_grant_first", 64'(idx), 64'd0);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0);
    wait_accept(idx, acc);
    check("t5_grant_second", 64'(idx), 64'd3);
    @(negedge clk);
    set_req(3, 1'b0, 32'd0);
    drain();

    // Spurious converter strobe in IDLE while requester 1 is pending.
    set_req(1, 1'b1, 32'd6);
    inj_data  = 32'h1234_5678;
    inj_valid = 1'b1;
    push_exp(1, 32'h40C0_0000);
    wait_accept(idx, acc);
    check("t6_grant", 64'(idx), 64'd1);
    @(negedge clk);
    inj_valid = 1'b0;
    set_req(1, 1'b0, 32'd0);
    drain();
    check("t6_latency", 64'(last_rsp_cyc - acc), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
